// File: rtl/ga_pkg.sv
// Shared types and default widths for the GA mutation datapath.
// Holds the mutation FSM state enum and chromosome/random widths.
package ga_pkg;

  localparam int GA_CHROM_W = 16;
  localparam int GA_RAND_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    MUTATE,
    DONE
  } mutation_state_t;

endpackage

// File: rtl/ga_mutation_unit.sv
// Bit-serial GA mutation: each bit flips when rand_in < latched rate.
// Ports: start/chrom_in/mutation_rate in, rand_in/rand_en to LFSR,
// chrom_out/flip_count out with out_valid/out_ready handshake, busy.
module ga_mutation_unit
  import ga_pkg::*;
#(
  parameter int CHROM_W = GA_CHROM_W,
  parameter int RAND_W  = GA_RAND_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CHROM_W-1:0]           chrom_in,
  input  logic [RAND_W-1:0]            mutation_rate,
  input  logic [RAND_W-1:0]            rand_in,
  output logic                         rand_en,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHROM_W-1:0]           chrom_out,
  output logic [$clog2(CHROM_W+1)-1:0] flip_count
);

  localparam int IDX_W = $clog2(CHROM_W);
  localparam int FC_W  = $clog2(CHROM_W+1);

  mutation_state_t    state, state_nx;
  logic [IDX_W-1:0]   bit_idx;
  logic [FC_W-1:0]    flip_cnt;
  logic [CHROM_W-1:0] work;
  logic [RAND_W-1:0]  rate_q;
  logic               hit;
  logic               last;

  assign hit  = rand_in < rate_q;
  assign last = bit_idx == IDX_W'(CHROM_W-1);

  always_comb begin
    state_nx  = state;
    rand_en   = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = MUTATE;
      end
      MUTATE: begin
        rand_en = 1'b1;
        busy    = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      flip_cnt <= '0;
      work     <= '0;
      rate_q   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            work     <= chrom_in;
            rate_q   <= mutation_rate;
            bit_idx  <= '0;
            flip_cnt <= '0;
          end
        end
        MUTATE: begin
          if (hit) begin
            work     <= work ^ (CHROM_W'(1) << bit_idx);
            flip_cnt <= flip_cnt + FC_W'(1);
          end
          // hold on the last bit; DONE follows
          if (!last) bit_idx <= bit_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign chrom_out  = work;
  assign flip_count = flip_cnt;

endmodule

// File: tb/tb_ga_mutation_unit.sv
// Self-checking bench for ga_mutation_unit: vector table, random ops
// against a word-list reference model, LFSR run, backpressure, reset.
module tb_ga_mutation_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] chrom_in;
  logic [7:0]  mutation_rate;
  logic [7:0]  rand_in;
  logic [7:0]  rand_drv;
  logic        rand_en;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] chrom_out;
  logic [4:0]  flip_count;

  logic        use_lfsr;
  logic [7:0]  lfsr_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rand_in = use_lfsr ? lfsr_q : rand_drv;

  // upstream LFSR stand-in: 8-bit Galois, advances on rand_en
  always @(posedge clk) begin
    if (rst) lfsr_q <= 8'hFF;
    else if (use_lfsr && rand_en)
      lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  ga_mutation_unit #(.CHROM_W(16), .RAND_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .chrom_in      (chrom_in),
    .mutation_rate (mutation_rate),
    .rand_in       (rand_in),
    .rand_en       (rand_en),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .chrom_out     (chrom_out),
    .flip_count    (flip_count)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode: 0 random, 1 constant k, 2 alternating 00/FF, 3 LFSR
  task automatic do_op(input logic [15:0] c, input logic [7:0] r,
                       input int mode, input logic [7:0] k,
                       input logic use_exp, input logic [15:0] ec,
                       input logic [4:0] ef, input string nm);
    logic [7:0]  words[$];
    logic [7:0]  w;
    logic [15:0] mc;
    int          mf;
    int          lat;
    int          en_cnt;
    use_lfsr = (mode == 3);
    @(negedge clk);
    chrom_in      = c;
    mutation_rate = r;
    start         = 1'b1;
    @(posedge clk);
    lat    = 1;
    en_cnt = 0;
    @(negedge clk);
    start         = 1'b0;
    chrom_in      = 16'($urandom);
    mutation_rate = 8'($urandom);
    while (!out_valid && lat < 40) begin
      if (rand_en) begin
        case (mode)
          0:       w = 8'($urandom);
          1:       w = k;
          2:       w = (en_cnt % 2 == 0) ? 8'h00 : 8'hFF;
          default: w = lfsr_q;
        endcase
        rand_drv = w;
        words.push_back(w);
        en_cnt++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    mc = c;
    mf = 0;
    foreach (words[i]) begin
      if (words[i] < r) begin
        mc[i] = ~mc[i];
        mf++;
      end
    end
    if (use_exp) begin
      mc = ec;
      mf = int'(ef);
    end
    check({nm, " latency"}, 64'(lat), 64'd17);
    check({nm, " rand_en cycles"}, 64'(en_cnt), 64'd16);
    check({nm, " chrom_out"}, 64'(chrom_out), 64'(mc));
    check({nm, " flip_count"}, 64'(flip_count), 64'(mf));
    use_lfsr = 1'b0;
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " out_valid after accept"}, 64'(out_valid), 64'd0);
    check({nm, " busy after accept"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [15:0] c;
    logic [7:0]  r;
    int          mode;
    logic [7:0]  k;
    logic [15:0] ec;
    logic [4:0]  ef;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] hold_c;
    logic [4:0]  hold_f;
    vecs.push_back('{16'hA5A5, 8'h00, 0, 8'h00, 16'hA5A5, 5'd0, "rate0"});
    vecs.push_back('{16'hA5A5, 8'h01, 1, 8'h00, 16'h5A5A, 5'd16, "rate1"});
    vecs.push_back('{16'h0000, 8'h80, 2, 8'h00, 16'h5555, 5'd8, "alt"});
    vecs.push_back('{16'h0000, 8'hFF, 1, 8'hFE, 16'hFFFF, 5'd16, "ff_fe"});
    vecs.push_back('{16'h1234, 8'hFF, 1, 8'hFF, 16'h1234, 5'd0, "ff_ff"});
    vecs.push_back('{16'hF00F, 8'h10, 1, 8'h10, 16'hF00F, 5'd0, "eq"});
    vecs.push_back('{16'hF00F, 8'h11, 1, 8'h10, 16'h0FF0, 5'd16, "lt"});

    rst = 1'b1;
    start = 1'b0;
    chrom_in = '0;
    mutation_rate = '0;
    rand_drv = '0;
    out_ready = 1'b0;
    use_lfsr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset rand_en", 64'(rand_en), 64'd0);
    check("reset chrom_out", 64'(chrom_out), 64'd0);
    check("reset flip_count", 64'(flip_count), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].c, vecs[i].r, vecs[i].mode, vecs[i].k,
            1'b1, vecs[i].ec, vecs[i].ef, vecs[i].nm);
      release_out(vecs[i].nm);
    end

    for (int i = 0; i < 12; i++) begin
      do_op(16'($urandom), 8'($urandom), 0, 8'h00,
            1'b0, 16'h0, 5'd0, "random");
      release_out("random");
    end

    do_op(16'h0000, 8'h80, 3, 8'h00, 1'b0, 16'h0, 5'd0, "lfsr");
    release_out("lfsr");

    // backpressure: hold result, ignore start while busy
    do_op(16'hA5A5, 8'h01, 1, 8'h00, 1'b1, 16'h5A5A, 5'd16, "bp");
    hold_c = 16'h5A5A;
    hold_f = 5'd16;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start    = (i == 2);
      chrom_in = 16'hFFFF;
      check("bp out_valid held", 64'(out_valid), 64'd1);
      check("bp chrom_out stable", 64'(chrom_out), 64'(hold_c));
      check("bp flip_count stable", 64'(flip_count), 64'(hold_f));
    end
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check("bp start+ready ignored busy", 64'(busy), 64'd0);
    check("bp start+ready out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("bp stays idle", 64'(busy), 64'd0);

    // reset in the middle of MUTATE
    @(negedge clk);
    chrom_in      = 16'hA5A5;
    mutation_rate = 8'h01;
    rand_drv      = 8'h00;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst chrom_out", 64'(chrom_out), 64'd0);
    check("midrst flip_count", 64'(flip_count), 64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst rand_en", 64'(rand_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h3C3C, 8'h80, 0, 8'h00, 1'b0, 16'h0, 5'd0, "post_rst");
    release_out("post_rst");

    // reset while in DONE discards the result
    do_op(16'hA5A5, 8'h01, 1, 8'h00, 1'b1, 16'h5A5A, 5'd16, "done_rst");
    #1;
    rst = 1'b1;
    #1;
    check("donerst out_valid", 64'(out_valid), 64'd0);
    check("donerst chrom_out", 64'(chrom_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
